ioctl_upload_reader: RTL

// Server side of the data_io upload path: when the HPS/ARM reads core memory back
// (ioctl_upload), supplies ioctl_din byte-by-byte from a core RAM (NVRAM/hiscore).

---
 rtl/ioctl_upload_reader_if.sv | 20 ++
 rtl/ioctl_upload_reader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ioctl_upload_reader_if.sv
// ioctl_upload_reader_if
// Groups the data_io upload-side signals between data_io (master) and the
// upload reader (slave).
//   ioctl_upload  upload in progress (level)
//   ioctl_index   selected slot
//   ioctl_addr    byte address the next ioctl_rd will consume
//   ioctl_rd      1-cycle strobe: data_io has taken ioctl_din
//   ioctl_din     byte presented back to data_io
interface ioctl_upload_reader_if;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din;

    modport master (output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
                    input  ioctl_din);
    modport slave  (input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
                    output ioctl_din);
endinterface

// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader
// Serves HPS read-back of core memory (NVRAM/hiscore) over the data_io upload
// path. Freezes the core with pause_req, waits for it to drain, then prefetches
// one byte at a time from core RAM so ioctl_din is ready before each ioctl_rd.
// Ports:
//   clk_sys, res_n  clock, synchronous active-low reset
//   io              data_io upload bus (slave side)
//   pause_req       core freeze request
//   mem_addr/mem_rd core RAM read address and 1-cycle read strobe
//   mem_q           core RAM data, valid READ_LAT cycles after mem_rd
//   busy            FSM not idle
//   overrun         sticky: ioctl_rd arrived while no byte was ready
//   checksum        XOR of bytes delivered this upload
module ioctl_upload_reader #(
    parameter logic [7:0] UPL_INDEX  = 8'h02,
    parameter int         AW         = 10,
    parameter int         READ_LAT   = 2,
    parameter int         PAUSE_WAIT = 255,
    parameter logic [7:0] FILL       = 8'hFF
) (
    input  logic                  clk_sys,
    input  logic                  res_n,
    ioctl_upload_reader_if.slave  io,
    output logic                  pause_req,
    output logic [AW-1:0]         mem_addr,
    output logic                  mem_rd,
    input  logic [7:0]            mem_q,
    output logic                  busy,
    output logic                  overrun,
    output logic [7:0]            checksum
);
    // Counter is shared by the pause wait and the read-latency wait.
    localparam int CW = $clog2(PAUSE_WAIT + READ_LAT + 2);

    typedef enum logic [2:0] {S_IDLE, S_PAUSE, S_FETCH, S_READY, S_RELEASE} state_t;

    state_t          state_q, state_d;
    logic            active_q, active_d;
    logic [24:0]     addr_q, addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            issued_q, issued_d;
    logic [7:0]      din_q, din_d;
    logic            pause_q, pause_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_rd_q, mem_rd_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      csum_q, csum_d;

    logic act, in_range;

    // An index change while uploading deasserts act, so it is treated as a fall.
    assign act      = io.ioctl_upload && (io.ioctl_index == UPL_INDEX);
    // Addresses past the RAM span must never alias back into it.
    assign in_range = ((addr_q >> AW) == '0);

    always_comb begin
        state_d    = state_q;
        active_d   = act;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        issued_d   = issued_q;
        din_d      = din_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        overrun_d  = overrun_q;
        csum_d     = csum_q;

        // A strobe with no byte ready is dropped and flagged.
        if (io.ioctl_rd && (state_q == S_PAUSE || state_q == S_FETCH))
            overrun_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (act && !active_q) begin
                    state_d   = S_PAUSE;
                    overrun_d = 1'b0;
                    csum_d    = 8'h00;
                    cnt_d     = '0;
                end
            end
            S_PAUSE: begin
                if (!act) begin
                    state_d = S_RELEASE;
                end else if (cnt_q + CW'(1) >= CW'(PAUSE_WAIT)) begin
                    state_d  = S_FETCH;
                    addr_d   = io.ioctl_addr;
                    issued_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FETCH: begin
                if (!act) begin
                    // Drop any read in flight; its mem_q is never captured.
                    state_d  = S_RELEASE;
                    issued_d = 1'b0;
                end else if (!issued_q) begin
                    if (in_range) begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = addr_q[AW-1:0];
                        issued_d   = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        din_d   = FILL;
                        state_d = S_READY;
                    end
                end else if (cnt_q == CW'(READ_LAT)) begin
                    // cnt_q is 0 in the cycle mem_rd is high, so this is the
                    // cycle mem_q becomes valid.
                    din_d    = mem_q;
                    issued_d = 1'b0;
                    state_d  = S_READY;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_READY: begin
                // Checksum still takes a byte consumed in the same cycle as the fall.
                if (io.ioctl_rd) begin
                    csum_d = csum_q ^ din_q;
                    addr_d = addr_q + 25'd1;
                end
                if (!act) begin
                    state_d = S_RELEASE;
                end else if (io.ioctl_rd) begin
                    state_d  = S_FETCH;
                    issued_d = 1'b0;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they track state_q.
    assign busy_d  = (state_d != S_IDLE);
    assign pause_d = (state_d != S_IDLE) && (state_d != S_RELEASE);

    always_ff @(posedge clk_sys) begin
        if (!res_n) begin
            state_q    <= S_IDLE;
            active_q   <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            issued_q   <= 1'b0;
            din_q      <= 8'h00;
            pause_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            csum_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            issued_q   <= issued_d;
            din_q      <= din_d;
            pause_q    <= pause_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            csum_q     <= csum_d;
        end
    end

    assign io.ioctl_din = din_q;
    assign pause_req    = pause_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign checksum     = csum_q;
endmodule
